layer_mixer: RTL
================

Name: layer_mixer

Overview:
- Parametrised successor to the GPU's fixed cluster priority mux: composites LAYER_COUNT layer pixel streams into one VGA colour.
- Provides a programmable transparency key, a per-layer enable mask and a background colour.
- Control registers are double-buffered shadow→active and committed only at frame start, so reprogramming never tears mid-frame.
- Sits between the cluster outputs / vga_counter and the VGA pins; programmed via the waddr/wdata/wen port of axil_controller.

Parameters:
- LAYER_COUNT, 3, number of layer pixel inputs; layer 0 is highest priority.
- COLOR_WIDTH, 12, pixel width; must be a multiple of 3 (R/G/B equal slices, R in the MSBs).
- ADDR_WIDTH, 16, word-address width of the register write port.
- DATA_WIDTH, 32, write data width; must be ≥ max(LAYER_COUNT, COLOR_WIDTH).
- KEY_RESET, 12'hFFF, reset value of the transparency key.

Ports:
- clk  input  1  pixel-domain clock.
- rst  input  1  asynchronous, active-high reset.
- waddr  input  ADDR_WIDTH  register word address.
- wdata  input  DATA_WIDTH  register write data.
- wen  input  1  single-cycle write strobe.
- frame_start  input  1  one-cycle pulse at the first cycle of each frame, from vga_counter.
- visible_in  input  1  pixel in active area.
- hsync_in  input  1  horizontal sync in, active-low.
- vsync_in  input  1  vertical sync in, active-low.
- layer_pixel  input  LAYER_COUNT*COLOR_WIDTH  packed; layer i occupies bits [i*COLOR_WIDTH +: COLOR_WIDTH].
- red / green / blue  output  COLOR_WIDTH/3 each  composited colour.
- hsync_out / vsync_out  output  1  syncs delayed to match the colour latency.
- frame_count  output  16  number of frame_start pulses seen; wraps.
- commit_done  output  1  one-cycle pulse when a commit is applied.

Behaviour:
- Register map (word address):
  - 0 LAYER_EN: wdata[LAYER_COUNT-1:0].
  - 1 BG_COLOR: wdata[COLOR_WIDTH-1:0].
  - 2 KEY: wdata[COLOR_WIDTH-1:0].
  - 3 COMMIT: wdata[0]=1 sets pending; writing 0 has no effect.
  - 4 ALPHA_MASK: optional feature only.
  - Writes to any other address are ignored; there is no side effect.
- Writes to addresses 0–2 (and 4) update shadow registers only.
- On frame_start with pending=1:
  - all active registers load from the shadow registers;
  - pending clears;
  - commit_done pulses on the next cycle.
- frame_start with pending=0 leaves the active registers unchanged.
- Simultaneous events:
  - COMMIT write in the same cycle as frame_start: pending is set, and the commit applies at the following frame_start.
  - Shadow write in the same cycle as an applying frame_start: active takes the pre-write shadow value; the new value stays in the shadow register.
- frame_count increments on every frame_start and wraps 16'hFFFF→0.
- Pipeline, fixed 2-cycle latency from inputs to red/green/blue/hsync_out/vsync_out:
  - Stage 1 registers layer_pixel, visible_in, hsync_in and vsync_in.
  - Stage 2 registers the selected colour and the syncs.
- Selection uses the lowest index i with active LAYER_EN[i]=1 and pixel_i != active KEY.
  - If no layer qualifies, the output is active BG_COLOR.
  - If the stage-1 visible is 0, the output is 0 regardless of layers.
- Reset values:
  - active and shadow LAYER_EN all ones; BG_COLOR 0; KEY = KEY_RESET; pending 0;
  - frame_count 0; commit_done 0;
  - red/green/blue 0; hsync_out 1; vsync_out 1; pipeline valid/visible 0.
- Reset asserted mid-frame or mid-commit: returns to the reset values immediately; a pending commit is discarded.

Optional Feature:
- Macro: LAYER_MIXER_ALPHA_EN.
- Defined:
  - Register 4 ALPHA_MASK (wdata[LAYER_COUNT-1:0], shadowed and committed like the others, reset 0) is implemented.
  - If the winning layer w has ALPHA_MASK[w]=1, the output is the per-channel average of w and the next qualifying lower-priority layer. If no lower layer qualifies, w is averaged with BG_COLOR.
  - Each channel is (a+b)>>1, truncated.
  - Latency stays 2 cycles.
- Undefined: address 4 is ignored and there is no blending logic.

Test Plan:
- Reset with layer0=12'h123, visible=1 → two cycles later red=1, green=2, blue=3; hsync_out/vsync_out follow the inputs delayed by 2.
- layer0=12'hFFF (key), layer1=12'h0F0, layer2=12'h00F → output 12'h0F0. With all three layers at FFF and BG_COLOR committed to 12'h400 → output 12'h400.
- Write LAYER_EN=3'b110 and COMMIT mid-frame → output unchanged until frame_start. Then layer0 is masked and layer1 is shown; commit_done pulses once; frame_count increments.
- COMMIT write coincident with frame_start → no change at that frame; new values applied at the next frame_start.
- visible_in=0 with nonzero layers → RGB=0. Write to address 9 → no register changes. Assert rst mid-frame with pending=1 → all reset values; no commit at the next frame_start.
- (ALPHA_EN) ALPHA_MASK=3'b001, layer0=12'hF00, layer1=12'h0F0 → output 12'h770.

Source files
------------

// File: rtl/layer_mixer_if.sv
// Register write port into layer_mixer, driven by axil_controller.
interface layer_mixer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wen;

    modport master (output waddr, wdata, wen);
    modport slave  (input  waddr, wdata, wen);
endinterface

// File: rtl/layer_mixer.sv
// Layer compositor: priority select with colour key, enable mask and background,
// frame-synchronous register commit. Define LAYER_MIXER_ALPHA_EN for 50/50 blending.

module layer_qual #(
    parameter int COLOR_WIDTH = 12
) (
    input  logic [COLOR_WIDTH-1:0] pixel,
    input  logic [COLOR_WIDTH-1:0] key,
    input  logic                   en,
    output logic                   qual
);
    assign qual = en && (pixel != key);
endmodule

module layer_mixer #(
    parameter int                     LAYER_COUNT = 3,
    parameter int                     COLOR_WIDTH = 12,
    parameter int                     ADDR_WIDTH  = 16,
    parameter int                     DATA_WIDTH  = 32,
    parameter logic [COLOR_WIDTH-1:0] KEY_RESET   = 12'hFFF
) (
    input  logic                               clk,
    input  logic                               rst,
    layer_mixer_if.slave                       bus,
    input  logic                               frame_start,
    input  logic                               visible_in,
    input  logic                               hsync_in,
    input  logic                               vsync_in,
    input  logic [LAYER_COUNT*COLOR_WIDTH-1:0] layer_pixel,
    output logic [COLOR_WIDTH/3-1:0]           red,
    output logic [COLOR_WIDTH/3-1:0]           green,
    output logic [COLOR_WIDTH/3-1:0]           blue,
    output logic                               hsync_out,
    output logic                               vsync_out,
    output logic [15:0]                        frame_count,
    output logic                               commit_done
);
    localparam int CW = COLOR_WIDTH / 3;
    localparam logic [ADDR_WIDTH-1:0] A_EN     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_BG     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_KEY    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_COMMIT = ADDR_WIDTH'(3);
`ifdef LAYER_MIXER_ALPHA_EN
    localparam logic [ADDR_WIDTH-1:0] A_ALPHA  = ADDR_WIDTH'(4);
`endif

    logic [LAYER_COUNT-1:0] sh_en,  act_en;
    logic [COLOR_WIDTH-1:0] sh_bg,  act_bg;
    logic [COLOR_WIDTH-1:0] sh_key, act_key;
    logic                   pending;
`ifdef LAYER_MIXER_ALPHA_EN
    logic [LAYER_COUNT-1:0] sh_alpha, act_alpha;
`endif

    // Active copy loads from the pre-write shadow on a committing frame_start;
    // a COMMIT write in that same cycle re-arms pending for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en       <= '1;
            act_en      <= '1;
            sh_bg       <= '0;
            act_bg      <= '0;
            sh_key      <= KEY_RESET;
            act_key     <= KEY_RESET;
            pending     <= 1'b0;
            frame_count <= '0;
            commit_done <= 1'b0;
`ifdef LAYER_MIXER_ALPHA_EN
            sh_alpha    <= '0;
            act_alpha   <= '0;
`endif
        end else begin
            commit_done <= frame_start && pending;
            if (frame_start)
                frame_count <= frame_count + 16'd1;
            if (frame_start && pending) begin
                act_en  <= sh_en;
                act_bg  <= sh_bg;
                act_key <= sh_key;
`ifdef LAYER_MIXER_ALPHA_EN
                act_alpha <= sh_alpha;
`endif
                pending <= 1'b0;
            end
            if (bus.wen) begin
                case (bus.waddr)
                    A_EN:     sh_en  <= bus.wdata[LAYER_COUNT-1:0];
                    A_BG:     sh_bg  <= bus.wdata[COLOR_WIDTH-1:0];
                    A_KEY:    sh_key <= bus.wdata[COLOR_WIDTH-1:0];
                    A_COMMIT: if (bus.wdata[0]) pending <= 1'b1;
`ifdef LAYER_MIXER_ALPHA_EN
                    A_ALPHA:  sh_alpha <= bus.wdata[LAYER_COUNT-1:0];
`endif
                    default:  ;
                endcase
            end
        end
    end

    // Stage 1
    logic [LAYER_COUNT-1:0][COLOR_WIDTH-1:0] s1_pix;
    logic                                    s1_vis;
    logic [1:0]                              hs_pipe, vs_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_pix  <= '0;
            s1_vis  <= 1'b0;
            hs_pipe <= 2'b11;
            vs_pipe <= 2'b11;
        end else begin
            s1_pix  <= layer_pixel;
            s1_vis  <= visible_in;
            hs_pipe <= {hs_pipe[0], hsync_in};
            vs_pipe <= {vs_pipe[0], vsync_in};
        end
    end

    logic [LAYER_COUNT-1:0] qual;

    genvar g;
    generate
        for (g = 0; g < LAYER_COUNT; g++) begin : g_lane
            layer_qual #(.COLOR_WIDTH(COLOR_WIDTH)) u_qual (
                .pixel (s1_pix[g]),
                .key   (act_key),
                .en    (act_en[g]),
                .qual  (qual[g])
            );
        end
    endgenerate

    // Descending scan: the last hit is the lowest index; the hit before it
    // is the next lower-priority qualifier.
    logic [COLOR_WIDTH-1:0] first_pix, sel;
`ifdef LAYER_MIXER_ALPHA_EN
    logic [COLOR_WIDTH-1:0] sec_pix;
    logic                   first_alpha;
    logic [CW:0]            ch_sum;
`endif

    always_comb begin
        first_pix = act_bg;
`ifdef LAYER_MIXER_ALPHA_EN
        sec_pix     = act_bg;
        first_alpha = 1'b0;
        ch_sum      = '0;
`endif
        for (int i = LAYER_COUNT - 1; i >= 0; i--) begin
            if (qual[i]) begin
`ifdef LAYER_MIXER_ALPHA_EN
                sec_pix     = first_pix;
                first_alpha = act_alpha[i];
`endif
                first_pix = s1_pix[i];
            end
        end
        sel = first_pix;
`ifdef LAYER_MIXER_ALPHA_EN
        if (first_alpha) begin
            for (int c = 0; c < 3; c++) begin
                ch_sum = {1'b0, first_pix[c*CW +: CW]} + {1'b0, sec_pix[c*CW +: CW]};
                sel[c*CW +: CW] = ch_sum[CW:1];
            end
        end
`endif
    end

    // Stage 2
    logic [COLOR_WIDTH-1:0] s2_color;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_color <= '0;
        else
            s2_color <= s1_vis ? sel : '0;
    end

    assign red       = s2_color[2*CW +: CW];
    assign green     = s2_color[CW +: CW];
    assign blue      = s2_color[0 +: CW];
    assign hsync_out = hs_pipe[1];
    assign vsync_out = vs_pipe[1];
endmodule
